// File: rtl/mprjram_arb_pkg.sv
// Shared definitions for the mprjram Wishbone arbiter.
// Provides the FSM state type, the one-hot grant encoding, the default
// watchdog timeout and the arbitration helper used in the idle state.
package mprjram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int DEFAULT_TIMEOUT = 1023;

  // Round-robin pick: a lone requester wins outright; on a tie the master
  // that did not own the bus last time wins.
  function automatic logic [1:0] pick_winner(input logic       req0,
                                             input logic       req1,
                                             input logic [1:0] last);
    logic [1:0] win;
    win = GNT_NONE;
    if (req0 && req1) begin
      win = (last == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (req0) begin
      win = GNT_M0;
    end else if (req1) begin
      win = GNT_M1;
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog for the arbiter's granted transfer.
// Ports:
//   wb_clk_i  - clock
//   wb_rst_i  - asynchronous active-high reset
//   clr       - clears the count (no stall this cycle)
//   en        - a stall cycle is in progress (granted stb high, no ack)
//   expire    - high in the TIMEOUT-th consecutive stall cycle
module wb_watchdog
  import mprjram_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt;

  assign expire = en & (wd_cnt == LAST_CNT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt <= '0;
    end else if (clr || expire) begin
      wd_cnt <= '0;
    end else if (en) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mprjram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the user-project memory port.
// Round-robin arbitration, bus lock while the owner holds cyc, and a
// watchdog that terminates an un-acked transfer with err.
// Ports:
//   wb_clk_i, wb_rst_i         - clock, asynchronous active-high reset
//   m0_* / m1_*                - Wishbone classic master ports (requests in,
//                                ack/err/read data out)
//   s_*                        - Wishbone slave-side port to memory controller
//   grant_o                    - one-hot current owner (00 = none)
//   timeout_o                  - one-cycle pulse when the watchdog fires
module mprjram_wb_arbiter
  import mprjram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [DATA_W-1:0]   m0_dat_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [DATA_W-1:0]   m1_dat_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic                s_ack_i,
  input  logic [DATA_W-1:0]   s_dat_i,

  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e  state;
  logic [1:0]  grant;
  logic [1:0]  last_grant;
  logic [1:0]  winner;

  logic              g_cyc;
  logic              g_stb;
  logic              g_we;
  logic [SEL_W-1:0]  g_sel;
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_dat;

  logic wd_en;
  logic expire;

  assign winner = pick_winner(m0_cyc_i & m0_stb_i, m1_cyc_i & m1_stb_i, last_grant);

  // Granted master's request; zero when nobody owns the bus so the
  // slave side is quiet in IDLE and during reset.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    case (grant)
      GNT_M0: begin
        g_cyc = m0_cyc_i;
        g_stb = m0_stb_i;
        g_we  = m0_we_i;
        g_sel = m0_sel_i;
        g_adr = m0_adr_i;
        g_dat = m0_dat_i;
      end
      GNT_M1: begin
        g_cyc = m1_cyc_i;
        g_stb = m1_stb_i;
        g_we  = m1_we_i;
        g_sel = m1_sel_i;
        g_adr = m1_adr_i;
        g_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // A stall cycle is a granted strobe without ack; anything else restarts
  // the count, so a same-cycle ack always beats expiry.
  assign wd_en = (state == OWN) & g_stb & ~s_ack_i;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (~wd_en),
    .en       (wd_en),
    .expire   (expire)
  );

  // The expiring cycle already withdraws cyc/stb from the slave.
  assign s_cyc_o = g_cyc & ~expire;
  assign s_stb_o = g_stb & ~expire;
  assign s_we_o  = g_we;
  assign s_sel_o = g_sel;
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;

  assign m0_ack_o = (grant == GNT_M0) & s_ack_i;
  assign m1_ack_o = (grant == GNT_M1) & s_ack_i;
  assign m0_err_o = (grant == GNT_M0) & expire;
  assign m1_err_o = (grant == GNT_M1) & expire;
  assign m0_dat_o = (grant == GNT_M0) ? s_dat_i : '0;
  assign m1_dat_o = (grant == GNT_M1) ? s_dat_i : '0;

  assign grant_o   = grant;
  assign timeout_o = expire;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant      <= GNT_NONE;
      last_grant <= GNT_M1;
    end else begin
      case (state)
        IDLE: begin
          if (winner != GNT_NONE) begin
            grant <= winner;
            state <= OWN;
          end
        end
        OWN: begin
          // Release on owner's cyc drop or on watchdog expiry.
          if (expire || !g_cyc) begin
            last_grant <= grant;
            grant      <= GNT_NONE;
            state      <= IDLE;
          end
        end
        default: begin
          grant <= GNT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mprjram_wb_arbiter.md
# mprjram_wb_arbiter

Two-master Wishbone arbiter that shares the single user-project memory port (mprjram / SDRAM controller window at 0x3800_0000) between the management-core Wishbone bus (m0) and a second requester such as an LA-driven DMA or prefetch engine (m1). It sits in the user project between the two masters and the memory controller's Wishbone slave port. It applies round-robin arbitration with bus locking while the winner holds `cyc`, and a watchdog timeout that terminates hung transfers with `err`.

## Interface
- `ADDR_W`, 32, address width passed through.
- `DATA_W`, 32, data width; `sel` width is `DATA_W/8`.
- `TIMEOUT`, 1023, max cycles a granted `stb` may wait for `s_ack` before `err` (must be ≥ 2).
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1: master 0 Wishbone classic controls.
- `m0_sel_i` in DATA_W/8, `m0_adr_i` in ADDR_W, `m0_dat_i` in DATA_W: master 0 request.
- `m0_ack_o`, `m0_err_o` out 1, `m0_dat_o` out DATA_W: master 0 response.
- `m1_*`: identical port set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1, `s_sel_o` out DATA_W/8, `s_adr_o` out ADDR_W, `s_dat_o` out DATA_W: to memory controller.
- `s_ack_i` in 1, `s_dat_i` in DATA_W: from memory controller.
- `grant_o` out 2: one-hot current owner (00 = none).
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, OWN.
- IDLE: `req_k = mk_cyc_i & mk_stb_i`.
  - Only one master requesting: that master wins.
  - Both requesting: the master not equal to `last_grant` wins.
  - Latch the winner into `grant`, go to OWN.
  - `last_grant` resets to m1, so m0 wins the first tie.
- OWN: slave outputs are muxed combinationally from the granted master. Outputs are `s_cyc_o = cyc`, `s_stb_o = stb`, and `we/sel/adr/dat` pass-through.
  - `s_ack_i` routes combinationally to the granted master's `ack_o`.
  - `s_dat_i` routes combinationally to the granted master's `dat_o`.
  - The non-granted master sees `ack = err = 0` and `dat_o = 0`.
- Lock: the grant is held while the granted master's `cyc_i` stays high, including across multiple `stb` transfers.
  - When the granted master drops `cyc_i`, update `last_grant = grant`, clear the grant, and go to IDLE.
- Watchdog: `wd_cnt` counts cycles in OWN with granted `stb` high and `s_ack_i` low. It clears on `s_ack_i`, when `stb` is low, and in IDLE.
  - When `wd_cnt == TIMEOUT-1` and no ack arrives, the arbiter does all of the following in the same cycle: asserts the granted master's `err_o` for one cycle, pulses `timeout_o`, and forces `s_cyc_o = s_stb_o = 0`.
  - Next state is IDLE (the grant is force-released) and `last_grant` is updated.
- If `s_ack_i` arrives in IDLE (spurious), it is ignored: no master sees it.
- Reset (asynchronous, at any time including mid-transfer):
  - State IDLE, `grant_o = 00`, `last_grant = m1`, `wd_cnt = 0`.
  - All slave and master outputs are 0, `timeout_o = 0`.

## Timing
- Arbitration latency: a request present in IDLE on clock edge N gives `grant_o` and `s_stb_o` valid after edge N (cycle N+1).
- Ack and read data are combinational: master ack occurs in the same cycle as `s_ack_i`.
- Bubble: one IDLE cycle separates consecutive grants whenever `cyc` drops. There is no bubble for back-to-back `stb` within a held `cyc`.
- `err_o` and `timeout_o` are high for exactly one cycle, TIMEOUT cycles after the first un-acked `stb` cycle.
- Simultaneous `s_ack_i` and watchdog expiry: ack wins, no err.
- Simultaneous `cyc` drop by the owner and a new request from the other master: the other master is granted after the single IDLE cycle.

## Structure
- Package `mprjram_arb_pkg` holds:
  - state enum (IDLE, OWN),
  - grant encoding constants `GNT_NONE`, `GNT_M0`, `GNT_M1`,
  - default `TIMEOUT` value.
- One sub-module, `wb_watchdog`: a counter with `clr`/`en` inputs, a TIMEOUT parameter, and an `expire` output.
- The mux and FSM live in the top module.

## Test plan
- Reset: assert `wb_rst_i` mid-transfer.
  - All outputs read 0 and `grant_o = 00` immediately, without a clock edge.
- Single m0 write to `0x3800_0010` with data `0x0000003E`, slave acks after 3 cycles.
  - `s_stb_o` rises at cycle 1, `m0_ack_o` coincides with `s_ack_i`, the slave captures `0x3E`.
  - `m1_ack_o` stays 0.
- Both masters request in the same cycle from reset.
  - m0 is granted first; after m0 drops `cyc`, m1 is granted after a one-cycle IDLE.
  - On the next tie, m1 is granted (round-robin).
- m1 holds `cyc` for 4 reads (data `0x44`, `0x4A`, `0x50`, `0xAB51`) while m0 requests continuously.
  - m0 stays waiting until m1 drops `cyc`.
  - m1 receives all four data words in order.
- Slave never acks, TIMEOUT=16.
  - `m0_err_o` and `timeout_o` pulse 16 cycles after the first `stb`, `s_cyc_o` drops, and the FSM returns to IDLE.
  - A subsequent m1 request is granted.
- Ack on the exact expiry cycle: `ack` is delivered, no `err`, and `timeout_o` stays 0.
